bram_sr_writer: RTL and testbench
=================================

# bram_sr_writer

Write-side companion of the BRAM shift register: accepts a valid/ready sample stream and writes it into an internal dual-port RAM at a self-incrementing, wrapping address. It tracks fill level, flags when a full window of `RAM_DEPTH` samples is held, and exposes a synchronous random-access read port for the downstream circular reader. It sits between a streaming producer (e.g. a lowered convolution line feed) and the BRAM shift-register read logic in the HLS IP-core library.

## Interface
- `DATA_WIDTH`, 9, sample width in bits
- `ADDR_WIDTH`, 9, address width
- `RAM_DEPTH`, `1 << ADDR_WIDTH`, number of entries; must be ≥2 and ≤ `2**ADDR_WIDTH`
- `OVERWRITE`, 1, 1 = keep writing when full (oldest overwritten); 0 = stall when full until flush

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  1  producer has a sample
- `in_ready`  out  1  block accepts a sample this cycle
- `in_data`  in  DATA_WIDTH  sample
- `flush`  in  1  discard contents: pointer and count cleared
- `wr_ptr`  out  ADDR_WIDTH  address the next accepted sample will be written to
- `fill_count`  out  ADDR_WIDTH+1  valid entries held, saturates at RAM_DEPTH
- `primed`  out  1  fill_count == RAM_DEPTH
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_WIDTH  read address
- `rd_data`  out  DATA_WIDTH  read data
- `rd_valid`  out  1  rd_data valid this cycle

## Operation
- Accept = `in_valid && in_ready`. On accept: `mem[wr_ptr] <= in_data`; `wr_ptr` increments, wrapping from RAM_DEPTH-1 to 0 (explicit compare, not natural overflow, so non-power-of-two depths work).
- `fill_count` increments on accept while < RAM_DEPTH; holds at RAM_DEPTH thereafter.
- `in_ready` = `!flush && (OVERWRITE || !primed)`, registered-state-derived, combinational from `flush`.
- States: EMPTY (count 0), FILLING (0<count<DEPTH), FULL (count==DEPTH). EMPTY→FILLING on first accept; FILLING→FULL on the accept that makes count==DEPTH; any→EMPTY on `flush`. With OVERWRITE=0 FULL is left only by flush or reset.
- `flush` has priority over an accept in the same cycle: sample dropped (in_ready is 0), `wr_ptr`←0, `fill_count`←0 next edge. RAM contents not cleared.
- Read port: on `rd_en`, `rd_data <= mem[rd_addr]`, `rd_valid <= 1`; else `rd_valid <= 0`, `rd_data` holds. `rd_addr` ≥ RAM_DEPTH returns 0 with rd_valid 1.
- Same-address read and write in one cycle: read-first, returns previous contents.
- RAM array has no reset.

## Timing
- Reset values: `wr_ptr`=0, `fill_count`=0, `primed`=0, `rd_valid`=0, `rd_data`=0; `in_ready`=1 after reset deasserts (0 while reset high).
- Write latency: sample visible on read port when `rd_en` is issued the cycle after accept; data out one cycle after that.
- Read latency: exactly 1 cycle, fully pipelined, one read per cycle.
- `primed` rises the cycle after the RAM_DEPTH-th accept.
- Reset asserted mid-fill: all registers return to reset values immediately (async); in-flight read discarded.

## Structure
- Shared package `bram_sr_pkg`: state encoding (EMPTY/FILLING/FULL), `next_ptr` wrap function, shared with the reader.
- One sub-module: `sdp_ram` — simple dual-port RAM, one write port, one read-first synchronous read port, no reset; the controller wraps it.

## Test plan
- Reset, then 4 accepts of 0x001..0x004 at DEPTH=8 → wr_ptr=4, fill_count=4, primed=0; read addr 2 → rd_data=0x003 one cycle later.
- 8 accepts at DEPTH=8 → primed=1 after 8th, fill_count=8; 9th accept 0x1FF (OVERWRITE=1) → mem[0]=0x1FF, wr_ptr=1, count stays 8.
- OVERWRITE=0, DEPTH=8, 8 accepts → in_ready=0, further in_valid ignored, wr_ptr=0; flush → in_ready=1, fill_count=0 next cycle.
- flush and in_valid together with wr_ptr=5 → sample dropped, wr_ptr=0, fill_count=0; mem[5] unchanged.
- Write 0x0AA to addr 3 while rd_en at addr 3 holding 0x055 → rd_data=0x055; next read → 0x0AA.
- Async reset asserted mid-cycle at count 6 → wr_ptr, fill_count, primed, rd_valid zero without waiting for clock edge.

Source files
------------

// File: rtl/bram_sr_pkg.sv
// Definitions shared by the BRAM shift-register writer and its circular reader:
// fill-state encoding and the wrapping pointer increment.
package bram_sr_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } fill_state_t;

  // Explicit wrap so that non-power-of-two depths cycle correctly.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read-first synchronous read port.
// No reset on the array or the read register.
module sdp_ram #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-address
  // read returns the contents from before this cycle's write.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/bram_sr_writer.sv
// Write side of the BRAM shift register: streams samples into a wrapping RAM,
// tracks fill level / primed window and exposes a 1-cycle random-access read port.
module bram_sr_writer
  import bram_sr_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter bit OVERWRITE  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  primed,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  fill_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  accept;
  logic                  rd_in_range;
  logic                  ram_re;
  logic                  rd_zero_p1;
  logic [DATA_WIDTH-1:0] ram_q_p1;

  assign in_ready    = !reset && !flush && (OVERWRITE || state != ST_FULL);
  assign accept      = in_valid && in_ready;
  assign primed      = (state == ST_FULL);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign ram_re      = rd_en && rd_in_range;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      fill_count <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= ptr_next;
      fill_count <= count_next;
    end
  end

  // Flush wins over a same-cycle accept (in_ready is already low then).
  always_comb begin
    state_next = state;
    ptr_next   = wr_ptr;
    count_next = fill_count;
    if (flush) begin
      state_next = ST_EMPTY;
      ptr_next   = '0;
      count_next = '0;
    end else if (accept) begin
      ptr_next = ADDR_WIDTH'(next_ptr(32'(wr_ptr), 32'(RAM_DEPTH)));
      if (state != ST_FULL) count_next = fill_count + 1'b1;
      state_next = (count_next == DEPTH_C) ? ST_FULL : ST_FILLING;
    end
  end

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (RAM_DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (accept),
    .waddr(wr_ptr),
    .wdata(in_data),
    .re   (ram_re),
    .raddr(rd_addr),
    .q    (ram_q_p1)
  );

  // Read stage: the RAM register has no reset, so a flag forces zero after
  // reset and for out-of-range addresses; both hold while rd_en is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero_p1 <= !rd_in_range;
    end
  end

  assign rd_data = rd_zero_p1 ? '0 : ram_q_p1;

endmodule

// File: tb/tb_bram_sr_writer.sv
// Bench for bram_sr_writer: three instances (depth 8 overwrite, depth 8 stall,
// depth 6 overwrite) checked against a behavioural model, table vectors and corner sequences.
module tb_bram_sr_writer;

  localparam int N = 3;
  localparam int DEPTHS[N] = '{8, 8, 6};
  localparam bit OWS[N]    = '{1'b1, 1'b0, 1'b1};

  logic       clock;
  logic       reset      [N];
  logic       in_valid   [N];
  logic       in_ready   [N];
  logic [8:0] in_data    [N];
  logic       flush      [N];
  logic [2:0] wr_ptr     [N];
  logic [3:0] fill_count [N];
  logic       primed     [N];
  logic       rd_en      [N];
  logic [2:0] rd_addr    [N];
  logic [8:0] rd_data    [N];
  logic       rd_valid   [N];

  int nvec = 0;
  int nmis = 0;

  // Behavioural reference state
  int         m_ptr [N];
  int         m_cnt [N];
  logic [8:0] m_mem [N][8];
  bit         m_wr  [N][8];
  bit         m_rv  [N];
  logic [8:0] m_rd  [N];
  bit         m_rdk [N];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bram_sr_writer #(.DATA_WIDTH(9), .ADDR_WIDTH(3), .RAM_DEPTH(8), .OVERWRITE(1'b1)) dut0 (
    .clock(clock), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .flush(flush[0]), .wr_ptr(wr_ptr[0]), .fill_count(fill_count[0]),
    .primed(primed[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]));

  bram_sr_writer #(.DATA_WIDTH(9), .ADDR_WIDTH(3), .RAM_DEPTH(8), .OVERWRITE(1'b0)) dut1 (
    .clock(clock), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .flush(flush[1]), .wr_ptr(wr_ptr[1]), .fill_count(fill_count[1]),
    .primed(primed[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]));

  bram_sr_writer #(.DATA_WIDTH(9), .ADDR_WIDTH(3), .RAM_DEPTH(6), .OVERWRITE(1'b1)) dut2 (
    .clock(clock), .reset(reset[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .flush(flush[2]), .wr_ptr(wr_ptr[2]), .fill_count(fill_count[2]),
    .primed(primed[2]), .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .rd_valid(rd_valid[2]));

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input int i);
    return !flush[i] && (OWS[i] || m_cnt[i] < DEPTHS[i]);
  endfunction

  task automatic model_reset(input int i);
    m_ptr[i] = 0;
    m_cnt[i] = 0;
    m_rv[i]  = 1'b0;
    m_rd[i]  = '0;
    m_rdk[i] = 1'b1;
  endtask

  task automatic model_step(input int i);
    bit rdy;
    int a;
    rdy = model_ready(i);
    a   = int'(rd_addr[i]);
    if (rd_en[i]) begin
      m_rv[i] = 1'b1;
      if (a >= DEPTHS[i]) begin
        m_rd[i]  = '0;
        m_rdk[i] = 1'b1;
      end else begin
        m_rd[i]  = m_mem[i][a];
        m_rdk[i] = m_wr[i][a];
      end
    end else begin
      m_rv[i] = 1'b0;
    end
    if (in_valid[i] && rdy) begin
      m_mem[i][m_ptr[i]] = in_data[i];
      m_wr[i][m_ptr[i]]  = 1'b1;
      m_ptr[i] = (m_ptr[i] + 1) % DEPTHS[i];
      if (m_cnt[i] < DEPTHS[i]) m_cnt[i]++;
    end
    if (flush[i]) begin
      m_ptr[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic compare_all(input int i);
    chk($sformatf("wr_ptr[%0d]", i), int'(wr_ptr[i]), m_ptr[i]);
    chk($sformatf("fill_count[%0d]", i), int'(fill_count[i]), m_cnt[i]);
    chk($sformatf("primed[%0d]", i), int'(primed[i]), int'(m_cnt[i] == DEPTHS[i]));
    chk($sformatf("rd_valid[%0d]", i), int'(rd_valid[i]), int'(m_rv[i]));
    if (m_rdk[i]) chk($sformatf("rd_data[%0d]", i), int'(rd_data[i]), int'(m_rd[i]));
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      flush[i]    = 1'b0;
      rd_en[i]    = 1'b0;
    end
  endtask

  // Inputs already driven; checks in_ready before the edge, outputs after it.
  task automatic step_all(output bit rdy_seen [N]);
    #1;
    for (int i = 0; i < N; i++) begin
      rdy_seen[i] = in_ready[i];
      chk($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(model_ready(i)));
    end
    for (int i = 0; i < N; i++) model_step(i);
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) compare_all(i);
    idle_inputs();
  endtask

  task automatic cycle(input int i, input bit fl, input bit v, input logic [8:0] d,
                       input bit re, input logic [2:0] ra, output bit rdy);
    bit seen [N];
    flush[i]    = fl;
    in_valid[i] = v;
    in_data[i]  = d;
    rd_en[i]    = re;
    rd_addr[i]  = ra;
    step_all(seen);
    rdy = seen[i];
  endtask

  typedef struct {
    bit fl; bit v; logic [8:0] d; bit re; logic [2:0] ra;
    bit rdy; int ptr; int cnt; bit pr; bit rv; logic [8:0] rd;
  } vec_t;

  vec_t tbl[17];
  bit   rdy;
  bit   seen [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      reset[i] = 1'b1; in_data[i] = '0; rd_addr[i] = '0;
      for (int k = 0; k < 8; k++) m_wr[i][k] = 1'b0;
      model_reset(i);
    end
    idle_inputs();
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) chk($sformatf("ready_in_reset[%0d]", i), int'(in_ready[i]), 0);
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) reset[i] = 1'b0;
    #1;
    for (int i = 0; i < N; i++) compare_all(i);

    // Fill, read-back, prime, overwrite, then flush-with-valid at wr_ptr=5
    tbl[0]  = '{0, 1, 9'h001, 0, 0, 1, 1, 1, 0, 0, 9'h000};
    tbl[1]  = '{0, 1, 9'h002, 0, 0, 1, 2, 2, 0, 0, 9'h000};
    tbl[2]  = '{0, 1, 9'h003, 0, 0, 1, 3, 3, 0, 0, 9'h000};
    tbl[3]  = '{0, 1, 9'h004, 0, 0, 1, 4, 4, 0, 0, 9'h000};
    tbl[4]  = '{0, 0, 9'h000, 1, 2, 1, 4, 4, 0, 1, 9'h003};
    tbl[5]  = '{0, 1, 9'h005, 0, 0, 1, 5, 5, 0, 0, 9'h003};
    tbl[6]  = '{0, 1, 9'h006, 0, 0, 1, 6, 6, 0, 0, 9'h003};
    tbl[7]  = '{0, 1, 9'h007, 0, 0, 1, 7, 7, 0, 0, 9'h003};
    tbl[8]  = '{0, 1, 9'h008, 0, 0, 1, 0, 8, 1, 0, 9'h003};
    tbl[9]  = '{0, 1, 9'h1FF, 1, 0, 1, 1, 8, 1, 1, 9'h001};
    tbl[10] = '{0, 0, 9'h000, 1, 0, 1, 1, 8, 1, 1, 9'h1FF};
    tbl[11] = '{0, 1, 9'h020, 0, 0, 1, 2, 8, 1, 0, 9'h1FF};
    tbl[12] = '{0, 1, 9'h021, 0, 0, 1, 3, 8, 1, 0, 9'h1FF};
    tbl[13] = '{0, 1, 9'h022, 0, 0, 1, 4, 8, 1, 0, 9'h1FF};
    tbl[14] = '{0, 1, 9'h023, 0, 0, 1, 5, 8, 1, 0, 9'h1FF};
    tbl[15] = '{1, 1, 9'h1AB, 1, 5, 0, 0, 0, 0, 1, 9'h006};
    tbl[16] = '{0, 0, 9'h000, 1, 5, 1, 0, 0, 0, 1, 9'h006};
    for (int r = 0; r < 17; r++) begin
      cycle(0, tbl[r].fl, tbl[r].v, tbl[r].d, tbl[r].re, tbl[r].ra, rdy);
      chk($sformatf("tbl%0d.in_ready", r), int'(rdy), int'(tbl[r].rdy));
      chk($sformatf("tbl%0d.wr_ptr", r), int'(wr_ptr[0]), tbl[r].ptr);
      chk($sformatf("tbl%0d.fill_count", r), int'(fill_count[0]), tbl[r].cnt);
      chk($sformatf("tbl%0d.primed", r), int'(primed[0]), int'(tbl[r].pr));
      chk($sformatf("tbl%0d.rd_valid", r), int'(rd_valid[0]), int'(tbl[r].rv));
      chk($sformatf("tbl%0d.rd_data", r), int'(rd_data[0]), int'(tbl[r].rd));
    end

    // Stall mode: fill, blocked write, flush, then read-first collision at addr 3
    for (int k = 0; k < 8; k++)
      cycle(1, 0, 1, (k == 3) ? 9'h055 : 9'(9'h030 + k), 0, 0, rdy);
    chk("ow0_primed", int'(primed[1]), 1);
    cycle(1, 0, 1, 9'h1EE, 0, 0, rdy);
    chk("ow0_ready_full", int'(rdy), 0);
    chk("ow0_ptr_held", int'(wr_ptr[1]), 0);
    chk("ow0_count_held", int'(fill_count[1]), 8);
    cycle(1, 1, 0, 9'h000, 0, 0, rdy);
    chk("ow0_count_flushed", int'(fill_count[1]), 0);
    cycle(1, 0, 1, 9'h060, 0, 0, rdy);
    chk("ow0_ready_after_flush", int'(rdy), 1);
    cycle(1, 0, 1, 9'h061, 0, 0, rdy);
    cycle(1, 0, 1, 9'h062, 0, 0, rdy);
    cycle(1, 0, 1, 9'h0AA, 1, 3, rdy);
    chk("collide_old", int'(rd_data[1]), 9'h055);
    cycle(1, 0, 0, 9'h000, 1, 3, rdy);
    chk("collide_new", int'(rd_data[1]), 9'h0AA);

    // Out-of-range read on the depth-6 instance
    cycle(2, 0, 1, 9'h0F0, 0, 0, rdy);
    cycle(2, 0, 0, 9'h000, 1, 0, rdy);
    cycle(2, 0, 0, 9'h000, 1, 7, rdy);
    chk("oor_data", int'(rd_data[2]), 0);
    chk("oor_valid", int'(rd_valid[2]), 1);

    // Asynchronous reset mid-cycle with count 6 and a read in flight
    cycle(0, 1, 0, 9'h000, 0, 0, rdy);
    for (int k = 0; k < 6; k++) cycle(0, 0, 1, 9'(9'h070 + k), (k == 5), 3'd1, rdy);
    chk("pre_reset_count", int'(fill_count[0]), 6);
    #2;
    reset[0] = 1'b1;
    model_reset(0);
    #1;
    chk("async_wr_ptr", int'(wr_ptr[0]), 0);
    chk("async_fill_count", int'(fill_count[0]), 0);
    chk("async_primed", int'(primed[0]), 0);
    chk("async_rd_valid", int'(rd_valid[0]), 0);
    chk("async_rd_data", int'(rd_data[0]), 0);
    @(posedge clock); #1;
    reset[0] = 1'b0;

    // Randomized traffic on all instances at once
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        flush[i]    = ($urandom_range(0, 15) == 0);
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = 9'($urandom);
        rd_en[i]    = $urandom_range(0, 1) == 1;
        rd_addr[i]  = 3'($urandom);
      end
      step_all(seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
